// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory responder: RV32 load/store size
// encodings (also decoded upstream) and the access FSM state encoding.
package data_memory_pkg;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_mem_lane.sv
// Byte-lane steering for the data memory. The read side picks a byte or
// halfword out of the addressed word and extends it. The write side builds
// a byte-enable mask and replicates the store data into every lane.
// Address bits below the access size are ignored, so accesses are always
// treated as naturally aligned.
module data_mem_lane
    import data_memory_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byteOffset_i,
    input  logic [31:0] memWord_i,
    input  logic [31:0] writeData_i,
    output logic [31:0] loadData_o,
    output logic [3:0]  byteEnable_o,
    output logic [31:0] storeData_o
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Load path: select the addressed byte/halfword, then sign- or zero-extend it
    always_comb begin
        selByte    = memWord_i[8*byteOffset_i +: 8];
        selHalf    = byteOffset_i[1] ? memWord_i[31:16] : memWord_i[15:0];
        loadData_o = memWord_i;
        case (funct3_i)
            F3_BYTE:   loadData_o = {{24{selByte[7]}}, selByte};
            F3_HALF:   loadData_o = {{16{selHalf[15]}}, selHalf};
            F3_BYTE_U: loadData_o = {24'h0, selByte};
            F3_HALF_U: loadData_o = {16'h0, selHalf};
            default:   loadData_o = memWord_i;
        endcase
    end

    // Store path: enable only the lanes being written and copy the data into them
    always_comb begin
        byteEnable_o = 4'b1111;
        storeData_o  = writeData_i;
        case (funct3_i)
            F3_BYTE: begin
                byteEnable_o = 4'b0001 << byteOffset_i;
                storeData_o  = {4{writeData_i[7:0]}};
            end
            F3_HALF: begin
                byteEnable_o = byteOffset_i[1] ? 4'b1100 : 4'b0011;
                storeData_o  = {2{writeData_i[15:0]}};
            end
            default: begin
                byteEnable_o = 4'b1111;
                storeData_o  = writeData_i;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory for the pipelined RV32 core. A request seen in
// IDLE is latched, held for LATENCY cycles in ACCESS, performed on the last
// of those edges, and then reported in DONE, where the stall drops so the
// pipeline advances. Dropping the request mid-access (flush) or resetting
// abandons it with no side effects.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
)
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        busywait_o
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] wordIndex_q;
    logic [1:0]        byteOffset_q;
    logic [31:0]       writeData_q;
    logic [2:0]        funct3_q;
    logic              isWrite_q;
    logic [31:0]       readData_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic        req;
    logic        accessEdge;
    logic        memWe;
    logic [31:0] memWord;
    logic [31:0] loadData;
    logic [3:0]  byteEnable;
    logic [31:0] storeData;
    logic        unusedAddrBits;

    // Address bits above the array size are dropped so addresses wrap
    assign unusedAddrBits = ^address_i[31:ADDR_W+2];

    assign req        = mem_read_i | mem_write_i;
    assign cnt_d      = cnt_q + CNT_W'(1);
    assign accessEdge = (state_q == ST_ACCESS) && req && (cnt_q == LAST_CNT) && !reset_i;
    assign memWe      = accessEdge && isWrite_q;
    assign memWord    = mem_q[wordIndex_q];
    assign busywait_o = req && (state_q != ST_DONE) && !reset_i;
    assign read_data_o = readData_q;

    data_mem_lane u_lane (
        .funct3_i     (funct3_q),
        .byteOffset_i (byteOffset_q),
        .memWord_i    (memWord),
        .writeData_i  (writeData_q),
        .loadData_o   (loadData),
        .byteEnable_o (byteEnable),
        .storeData_o  (storeData)
    );

    // Access sequencer: latch a request, count out the latency, capture load data,
    // and abandon the access if the request is flushed before it completes
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            readData_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        wordIndex_q  <= address_i[ADDR_W+1:2];
                        byteOffset_q <= address_i[1:0];
                        writeData_q  <= write_data_i;
                        funct3_q     <= funct3_i;
                        isWrite_q    <= mem_write_i;
                        cnt_q        <= '0;
                        state_q      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_d;
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == LAST_CNT) begin
                        if (!isWrite_q) begin
                            readData_q <= loadData;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array: byte-lane write on the final access edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEnable[b]) begin
                    mem_q[wordIndex_q][8*b +: 8] <= storeData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Testbench for data_memory. A byte-addressed reference memory predicts load
// results and the stall/result timeline of each access; one compare process
// checks the outputs every cycle, and literal checks pin key results.
module tb_data_memory;

    localparam int LATENCY     = 4;
    localparam int DEPTH_WORDS = 256;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        busywait;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic        checkEn     = 1'b0;
    logic        expBusy     = 1'b0;
    logic [31:0] expRead     = 32'h0;
    int          busyCount   = 0;
    logic [7:0]  modelMem [MEM_BYTES];

    data_memory #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .mem_read_i   (memRead),
        .mem_write_i  (memWrite),
        .funct3_i     (funct3),
        .address_i    (address),
        .write_data_i (writeData),
        .read_data_o  (readData),
        .busywait_o   (busywait)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Record one comparison and report it if it disagrees
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Number of bytes touched by an access of the given kind
    function automatic int accessSize(input logic [2:0] f3, input bit isStore);
        if (isStore) begin
            if (f3 == 3'b000) return 1;
            if (f3 == 3'b001) return 2;
            return 4;
        end
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference store: little-endian, aligned down, wrapping modulo the memory size
    function automatic void modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int size = accessSize(f3, 1'b1);
        int unsigned base = ((addr % MEM_BYTES) / size) * size;
        for (int i = 0; i < size; i++) begin
            modelMem[base + i] = wd[8*i +: 8];
        end
    endfunction

    // Reference load: gather bytes, then sign-extend unless an unsigned load
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
        int size = accessSize(f3, 1'b0);
        int unsigned base = ((addr % MEM_BYTES) / size) * size;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < size; i++) begin
            v = v | (32'(modelMem[base + i]) << (8 * i));
        end
        if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    // Per-cycle comparison of stall and load result against the expected timeline
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busywait", {31'b0, busywait}, {31'b0, expBusy});
            checkOutput("readData", readData, expRead);
            if (busywait === 1'b1) busyCount++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One complete access; called just after a rising edge, returns just after one
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
        memRead   = rd;
        memWrite  = wr;
        funct3    = f3;
        address   = addr;
        writeData = wd;
        expBusy   = 1'b1;
        busyCount = 0;
        repeat (LATENCY + 1) begin
            @(posedge clk);
            #1;
        end
        expBusy = 1'b0;
        if (wr) modelStore(f3, addr, wd);
        else    expRead = modelLoad(f3, addr);
        @(posedge clk);
        #1;
        checkOutput("stallLength", busyCount, LATENCY + 1);
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Store abandoned in its second ACCESS cycle by a flush or by reset
    task automatic applyAbort(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input bit useReset);
        memRead   = 1'b0;
        memWrite  = 1'b1;
        funct3    = f3;
        address   = addr;
        writeData = wd;
        expBusy   = 1'b1;
        busyCount = 0;
        idle(2);
        if (useReset) reset = 1'b1;
        else          memWrite = 1'b0;
        expBusy = 1'b0;
        idle(1);
        if (useReset) begin
            expRead = 32'h0;
            checkOutput("resetAbortReadData", readData, 32'h0);
            reset    = 1'b0;
            memWrite = 1'b0;
        end
        checkOutput("abortStallLength", busyCount, 2);
    endtask

    initial begin
        reset     = 1'b1;
        memRead   = 1'b1;
        memWrite  = 1'b0;
        funct3    = 3'b010;
        address   = 32'h0;
        writeData = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) modelMem[i] = 8'h00;

        @(posedge clk);
        #1;
        checkEn = 1'b1;
        idle(1);
        checkOutput("resetReadData", readData, 32'h0);
        checkOutput("resetBusy", {31'b0, busywait}, 32'h0);
        reset   = 1'b0;
        memRead = 1'b0;
        idle(1);

        $display("[TB] word store/load timing");
        applyStimulus(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        applyStimulus(1, 0, 3'b010, 32'h10, 32'h0);
        checkOutput("lwDeadbeef", readData, 32'hDEADBEEF);
        idle(2);

        $display("[TB] sign and zero extension");
        applyStimulus(0, 1, 3'b010, 32'h20, 32'h80FF7F01);
        applyStimulus(1, 0, 3'b000, 32'h21, 32'h0);
        checkOutput("lb21", readData, 32'h0000007F);
        applyStimulus(1, 0, 3'b000, 32'h22, 32'h0);
        checkOutput("lb22", readData, 32'hFFFFFFFF);
        applyStimulus(1, 0, 3'b100, 32'h23, 32'h0);
        checkOutput("lbu23", readData, 32'h00000080);
        applyStimulus(1, 0, 3'b001, 32'h22, 32'h0);
        checkOutput("lh22", readData, 32'hFFFF80FF);
        applyStimulus(1, 0, 3'b101, 32'h22, 32'h0);
        checkOutput("lhu22", readData, 32'h000080FF);

        $display("[TB] byte-lane masking and forced alignment");
        applyStimulus(0, 1, 3'b010, 32'h30, 32'h0);
        applyStimulus(0, 1, 3'b000, 32'h31, 32'h12345678);
        applyStimulus(0, 1, 3'b001, 32'h32, 32'hAAAABBBB);
        applyStimulus(1, 0, 3'b010, 32'h30, 32'h0);
        checkOutput("lwMasked", readData, 32'hBBBB7800);
        applyStimulus(1, 0, 3'b001, 32'h33, 32'h0);
        checkOutput("lhMisaligned", readData, 32'hFFFFBBBB);
        applyStimulus(1, 0, 3'b010, 32'h31, 32'h0);
        checkOutput("lwMisaligned", readData, 32'hBBBB7800);

        $display("[TB] flush abort");
        applyStimulus(0, 1, 3'b010, 32'h40, 32'h12345678);
        idle(1);
        applyAbort(3'b010, 32'h40, 32'h55, 1'b0);
        idle(1);
        applyStimulus(1, 0, 3'b010, 32'h40, 32'h0);
        checkOutput("lwAfterFlush", readData, 32'h12345678);

        $display("[TB] address wrap");
        applyStimulus(0, 1, 3'b010, 32'h400, 32'h11);
        applyStimulus(1, 0, 3'b010, 32'h0, 32'h0);
        checkOutput("lwWrapped", readData, 32'h00000011);

        $display("[TB] simultaneous read and write");
        applyStimulus(1, 1, 3'b010, 32'h50, 32'h99);
        checkOutput("rdwrHoldsReadData", readData, 32'h00000011);
        applyStimulus(1, 0, 3'b010, 32'h50, 32'h0);
        checkOutput("lwAfterRdWr", readData, 32'h00000099);

        $display("[TB] non-standard funct3 and halfword lanes");
        applyStimulus(0, 1, 3'b111, 32'h70, 32'hCAFEF00D);
        applyStimulus(1, 0, 3'b011, 32'h70, 32'h0);
        checkOutput("lwOtherF3", readData, 32'hCAFEF00D);
        applyStimulus(1, 0, 3'b001, 32'h72, 32'h0);
        checkOutput("lhUpper", readData, 32'hFFFFCAFE);
        applyStimulus(1, 0, 3'b101, 32'h71, 32'h0);
        checkOutput("lhuLower", readData, 32'h0000F00D);
        applyStimulus(1, 0, 3'b100, 32'h73, 32'h0);
        checkOutput("lbuTop", readData, 32'h000000CA);

        $display("[TB] reset during access");
        applyStimulus(0, 1, 3'b010, 32'h60, 32'h0000600D);
        applyStimulus(1, 0, 3'b010, 32'h60, 32'h0);
        checkOutput("lwBeforeReset", readData, 32'h0000600D);
        applyAbort(3'b010, 32'h60, 32'h00000BAD, 1'b1);
        idle(1);
        applyStimulus(1, 0, 3'b010, 32'h60, 32'h0);
        checkOutput("lwAfterResetAbort", readData, 32'h0000600D);
        idle(2);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
